// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencer for a 5-stage pipe.
// Covers load-use bubbles (ID vs EX), data-memory wait freezes and EX-resolved
// redirects. It also keeps saturating counters of stall cycles and redirect
// events. Control outputs are Mealy, meaning they are built from the current
// state and the current inputs. They are forced low while rst is high.
module hazard_ctrl #(
  parameter int LOADUSE_CYCLES = 1,  // bubbles per load-use hazard, 1..3
  parameter int FLUSH_CYCLES   = 1,  // flush cycles per redirect, 1..3
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1addr,
  input  logic [4:0]       id_rs2addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rdaddr,
  input  logic             ex_regwr,
  input  logic             ex_isload,
  input  logic             ex_willjmp,
  input  logic             dmem_busy,
  output logic             stall,
  output logic             if_hold,
  output logic             mem_hold,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, LDUSE, FLUSH, MEMWAIT} state_t;

  // Reload values for the down-counter. The state that consumes a reload
  // value is only reachable when its cycle count is above 1, so the reload is
  // always at least 1.
  localparam logic [1:0] LU_RELOAD = 2'(LOADUSE_CYCLES - 1);
  localparam logic [1:0] FL_RELOAD = 2'(FLUSH_CYCLES - 1);

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       lu;
  logic       stall_c, if_hold_c, mem_hold_c, ifid_flush_c, idex_flush_c;
  logic       redirect;

  // Load-use hazard: EX loads into a nonzero register that ID is about to read.
  always_comb begin
    lu = ex_isload && ex_regwr && (ex_rdaddr != 5'd0) &&
         ((id_uses_rs1 && (id_rs1addr == ex_rdaddr)) ||
          (id_uses_rs2 && (id_rs2addr == ex_rdaddr)));
  end

  // State and down-counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and raw controls. The priority is the same in every state:
  // a dmem wait wins first, a redirect second, and only then does
  // state-specific work run. MEMWAIT with dmem_busy low evaluates like RUN.
  // So a hazard or redirect that was held in the frozen pipe is handled on
  // the first free cycle.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    stall_c      = 1'b0;
    if_hold_c    = 1'b0;
    mem_hold_c   = 1'b0;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    redirect     = 1'b0;
    if (dmem_busy) begin
      // Freeze the whole pipe. Any remaining bubbles or flushes are dropped.
      stall_c    = 1'b1;
      if_hold_c  = 1'b1;
      mem_hold_c = 1'b1;
      state_nxt  = MEMWAIT;
    end else if (ex_willjmp) begin
      // A redirect kills the wrong-path instructions. It also kills any
      // pending load-use bubble, because the dependent ID instruction is
      // itself on the wrong path.
      ifid_flush_c = 1'b1;
      idex_flush_c = 1'b1;
      redirect     = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_nxt = FLUSH;
        cnt_nxt   = FL_RELOAD;
      end else begin
        state_nxt = RUN;
      end
    end else begin
      case (state)
        LDUSE: begin
          stall_c   = 1'b1;
          if_hold_c = 1'b1;
          if (cnt == 2'd1) state_nxt = RUN;
          else             cnt_nxt   = cnt - 2'd1;
        end
        FLUSH: begin
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
          if (cnt == 2'd1) state_nxt = RUN;
          else             cnt_nxt   = cnt - 2'd1;
        end
        default: begin
          // RUN, or MEMWAIT on the cycle the memory releases.
          state_nxt = RUN;
          if (lu) begin
            stall_c   = 1'b1;
            if_hold_c = 1'b1;
            if (LOADUSE_CYCLES > 1) begin
              state_nxt = LDUSE;
              cnt_nxt   = LU_RELOAD;
            end
          end
        end
      endcase
    end
  end

  // Controls are held low throughout a reset cycle, whatever the inputs are.
  assign stall      = ~rst & stall_c;
  assign if_hold    = ~rst & if_hold_c;
  assign mem_hold   = ~rst & mem_hold_c;
  assign ifid_flush = ~rst & ifid_flush_c;
  assign idex_flush = ~rst & idex_flush_c;

  // Saturating performance counters: stall cycles and redirect events.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_c && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (redirect && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
